// File: rtl/abc_lane_packer.sv
// abc_lane_packer: gathers a serial stream of 32-bit words into an No1-lane
// packed vector with a per-lane valid mask. A burst closes on the last lane or
// on in_last. A single completed vector can wait in the fill buffer while the
// output register is stalled, so a consumer stall never drops a word.

// One lane of the fill buffer. It holds one word and its mask bit, and it
// exposes a combinational view that includes a word being written this cycle.
module abc_lane_packer_lane (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        i_wr,
    input  logic        i_clr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_mask
);
    logic [31:0] r_data;
    logic        r_mask;

    // Lane storage: a clear wins over a write because the written word has
    // already been forwarded into the output register on the same edge.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_mask <= 1'b0;
        end else if (i_clr) begin
            r_data <= '0;
            r_mask <= 1'b0;
        end else if (i_wr) begin
            r_data <= i_data;
            r_mask <= 1'b1;
        end
    end

    // Forward view: the stored lane, or the incoming word when it lands here.
    always_comb begin
        o_data = i_wr ? i_data : r_data;
        o_mask = i_wr | r_mask;
    end
endmodule

module abc_lane_packer #(
    parameter int No1 = 6
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [No1-1:0][31:0]  abc,
    output logic [No1-1:0]        out_mask
);
    localparam int IdxW = $clog2(No1);

    typedef enum logic {S_FILL = 1'b0, S_PEND = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IdxW-1:0]       r_idx;
    logic                  r_out_valid;
    logic [No1-1:0][31:0]  r_abc;
    logic [No1-1:0]        r_out_mask;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_close;
    logic                  w_slot_free;
    logic                  w_drain;
    logic                  w_load_close;
    logic                  w_load_pend;
    logic                  w_load;
    logic [No1-1:0]        w_wr;
    logic [No1-1:0][31:0]  w_vec_data;
    logic [No1-1:0]        w_vec_mask;

    // Handshake and close decode. in_ready comes from state only, so there is
    // no combinational path from out_ready to in_ready.
    always_comb begin
        w_accept     = in_valid && w_in_ready;
        w_close      = w_accept && (in_last || (r_idx == IdxW'(No1 - 1)));
        w_drain      = r_out_valid && out_ready;
        w_slot_free  = !r_out_valid || out_ready;
        w_load_close = (r_state == S_FILL) && w_close && w_slot_free;
        w_load_pend  = (r_state == S_PEND) && w_drain;
        w_load       = w_load_close || w_load_pend;
    end

    // Per-lane fill buffer; the lane matching idx takes the accepted word.
    for (genvar gi = 0; gi < No1; gi++) begin : g_lane
        assign w_wr[gi] = w_accept && (r_idx == IdxW'(gi));
        abc_lane_packer_lane u_lane (
            .ck     (ck),
            .rst_n  (rst_n),
            .i_wr   (w_wr[gi]),
            .i_clr  (w_load),
            .i_data (in_data),
            .o_data (w_vec_data[gi]),
            .o_mask (w_vec_mask[gi])
        );
    end

    // FSM state register.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: park in PEND when a vector closes with the output busy.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_close && !w_slot_free) w_state_nxt = S_PEND;
            S_PEND:  if (w_drain)                 w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // FSM outputs: accept words only while filling.
    always_comb begin
        w_in_ready = (r_state == S_FILL);
    end

    // Lane index: advance per accepted word, wrap to 0 when a vector closes.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)        r_idx <= '0;
        else if (w_close)  r_idx <= '0;
        else if (w_accept) r_idx <= r_idx + IdxW'(1);
    end

    // Output register: load a finished vector, otherwise hold; drain clears
    // only the valid flag so data and mask keep their last values.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_abc       <= '0;
            r_out_mask  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_abc       <= w_vec_data;
            r_out_mask  <= w_vec_mask;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign abc       = r_abc;
    assign out_mask  = r_out_mask;
endmodule

// File: tb/tb_abc_lane_packer.sv
// Directed bench for abc_lane_packer (No1=6) with a scoreboard of expected
// vectors built from the words the bench drives.
module tb_abc_lane_packer;
    localparam int No1 = 6;

    logic                 ck = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [No1-1:0][31:0] abc;
    logic [No1-1:0]       out_mask;

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    int pop_cnt = 0;

    logic [No1-1:0][31:0] q_data[$];
    logic [No1-1:0]       q_mask[$];
    logic [No1-1:0][31:0] m_vec = '0;
    logic [No1-1:0]       m_mask = '0;
    int                   m_idx = 0;

    abc_lane_packer #(.No1(No1)) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .abc       (abc),
        .out_mask  (out_mask)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Drive one word; returns #1 after the edge that accepted it.
    task automatic send_word(input logic [31:0] d, input logic last);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge ck);
            if (in_ready === 1'b1) begin
                m_vec[m_idx]  = d;
                m_mask[m_idx] = 1'b1;
                if (last || m_idx == No1 - 1) begin
                    q_data.push_back(m_vec);
                    q_mask.push_back(m_mask);
                    m_vec  = '0;
                    m_mask = '0;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
                done = 1;
            end else begin
                stall_cnt++;
            end
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) chk("send_timeout", 1'b0, 1'b1);
    endtask

    // Output monitor: compare each handshaken vector against the scoreboard
    // and check that a stalled vector stays stable.
    initial begin
        logic                 prev_hold;
        logic [No1-1:0][31:0] prev_abc;
        logic [No1-1:0]       prev_mask;
        prev_hold = 1'b0;
        prev_abc  = '0;
        prev_mask = '0;
        forever begin
            @(negedge ck);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && out_valid === 1'b1) begin
                    chk("hold_abc", abc, prev_abc);
                    chk("hold_mask", out_mask, prev_mask);
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (q_data.size() == 0) begin
                        chk("unexpected_vector", 1'b1, 1'b0);
                    end else begin
                        chk("sb_abc", abc, q_data.pop_front());
                        chk("sb_mask", out_mask, q_mask.pop_front());
                        pop_cnt++;
                    end
                end
                prev_hold = (out_valid === 1'b1) && (out_ready === 1'b0);
                prev_abc  = abc;
                prev_mask = out_mask;
            end
        end
    end

    initial begin
        int p0;
        // Reset values
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_abc", abc, '0);
        chk("rst_mask", out_mask, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // 1: full burst, 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_word(32'h10 + i, 1'b0);
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_lane0", abc[0], 32'h10);
        chk("t1_lane5", abc[5], 32'h15);
        chk("t1_mask", out_mask, 6'h3F);
        step();
        chk("t1_drain_valid", out_valid, 1'b0);
        chk("t1_drain_keep_mask", out_mask, 6'h3F);

        // 2: short burst with in_last
        send_word(32'hA0, 1'b0);
        send_word(32'hA1, 1'b0);
        send_word(32'hA2, 1'b1);
        chk("t2_out_valid", out_valid, 1'b1);
        chk("t2_mask", out_mask, 6'h07);
        chk("t2_hi_zero", abc[5:3], '0);
        chk("t2_lane2", abc[2], 32'hA2);
        step();

        // 3: stall with 12 words, pend, then release without bubble
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) send_word(32'h300 + i, 1'b0);
        chk("t3_in_ready_low", in_ready, 1'b0);
        chk("t3_held_lane0", abc[0], 32'h301);
        step();
        step();
        chk("t3_still_pend", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        chk("t3_v2_valid", out_valid, 1'b1);
        chk("t3_v2_lane0", abc[0], 32'h307);
        chk("t3_v2_lane5", abc[5], 32'h30C);
        chk("t3_in_ready_back", in_ready, 1'b1);
        step();
        chk("t3_drained", out_valid, 1'b0);

        // 4: 18 words back-to-back, in_ready never low
        stall_cnt = 0;
        p0 = pop_cnt;
        for (int i = 0; i < 18; i++) send_word(32'h400 + i, 1'b0);
        step();
        step();
        chk("t4_stalls", stall_cnt, 0);
        chk("t4_vectors", pop_cnt - p0, 3);

        // 5: drain and close on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_word(32'h500 + i, 1'b0);
        for (int i = 0; i < 5; i++) send_word(32'h510 + i, 1'b0);
        chk("t5_held_valid", out_valid, 1'b1);
        chk("t5_held_lane0", abc[0], 32'h500);
        out_ready = 1'b1;
        send_word(32'h515, 1'b0);
        chk("t5_valid_stays", out_valid, 1'b1);
        chk("t5_new_lane0", abc[0], 32'h510);
        chk("t5_in_ready", in_ready, 1'b1);
        step();

        // 6: reset mid-burst
        for (int i = 0; i < 3; i++) send_word(32'h600 + i, 1'b0);
        rst_n = 1'b0;
        m_vec  = '0;
        m_mask = '0;
        m_idx  = 0;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_abc", abc, '0);
        chk("t6_rst_mask", out_mask, '0);
        chk("t6_rst_in_ready", in_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 6; i++) send_word(32'h610 + i, 1'b0);
        chk("t6_mask", out_mask, 6'h3F);
        chk("t6_lane0", abc[0], 32'h610);
        step();
        step();
        chk("sb_empty", q_data.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
